// File: rtl/sync_fifo_param_pkg.sv
// Shared definitions for the parametrised synchronous FIFO.
//  - FifoDataWDef / FifoDepthDef: default width and depth.
//  - ptr_next: pointer increment with an explicit wrap at depth-1.
//    Depth need not be a power of two, so the wrap must be explicit.
package sync_fifo_param_pkg;

  localparam int unsigned FifoDataWDef = 8;
  localparam int unsigned FifoDepthDef = 16;

  function automatic int unsigned ptr_next(input int unsigned ptr, input int unsigned depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_param_ram.sv
// DATA_W x DEPTH register array with one write port and one registered read port.
// Ports:
//  clk, rst_n      clock, async active-low reset (clears the read register only)
//  we, waddr, wdata write port
//  re, raddr       read strobe/address; rdata updates on the edge after re
//  rdata           registered read data, holds when re is low
// A read and a write to the same address in one cycle return the old contents.
module sync_fifo_param_ram #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned AddrW  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [AddrW-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AddrW-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (re) begin
      rdata_q <= mem_q[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, almost-full/almost-empty
// flags, simultaneous read+write and a read-data valid strobe.
// Ports:
//  clk, rst_n          clock, async active-low reset
//  wr, bus_in          write request and data
//  rd                  read request
//  bus_out, rd_valid   registered read data and its one-cycle valid strobe
//  full, empty         count == DEPTH / count == 0
//  almost_full         count >= AFULL_TH
//  almost_empty        count <= AEMPTY_TH
//  count               current occupancy
// Optional feature macro FIFO_ERR_EN adds err_clr (in), overflow and underflow
// (sticky error outputs).
module sync_fifo_param
  import sync_fifo_param_pkg::*;
#(
  parameter int unsigned DATA_W    = FifoDataWDef,
  parameter int unsigned DEPTH     = FifoDepthDef,
  parameter int unsigned AFULL_TH  = 12,
  parameter int unsigned AEMPTY_TH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr,
  input  logic [DATA_W-1:0]          bus_in,
  input  logic                       rd,
  output logic [DATA_W-1:0]          bus_out,
  output logic                       rd_valid,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
`ifdef FIFO_ERR_EN
  input  logic                       err_clr,
  output logic                       overflow,
  output logic                       underflow,
`endif
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned AddrW = $clog2(DEPTH);
  localparam int unsigned CntW  = $clog2(DEPTH + 1);

  logic [AddrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AddrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             full_q, empty_q, afull_q, aempty_q, rd_valid_q;
  logic             wr_acc, rd_acc;

  // No bypass: a read at empty is dropped even with a concurrent write.
  assign rd_acc = rd & ~empty_q;
  // At full, a write fits only because the concurrent read frees a slot.
  assign wr_acc = wr & (~full_q | rd_acc);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_acc) wr_ptr_d = AddrW'(ptr_next(32'(wr_ptr_q), DEPTH));
    if (rd_acc) rd_ptr_d = AddrW'(ptr_next(32'(rd_ptr_q), DEPTH));
    unique case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // Flags come from count_d so they line up with the pointers after each edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      afull_q    <= 1'b0;
      aempty_q   <= 1'b1;
      rd_valid_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= (count_d == CntW'(DEPTH));
      empty_q    <= (count_d == '0);
      afull_q    <= (count_d >= CntW'(AFULL_TH));
      aempty_q   <= (count_d <= CntW'(AEMPTY_TH));
      rd_valid_q <= rd_acc;
    end
  end

  sync_fifo_param_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AddrW  (AddrW)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wr_acc),
    .waddr (wr_ptr_q),
    .wdata (bus_in),
    .re    (rd_acc),
    .raddr (rd_ptr_q),
    .rdata (bus_out)
  );

`ifdef FIFO_ERR_EN
  logic overflow_q, underflow_q;

  // Set wins over a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= (wr & ~wr_acc) | (overflow_q & ~err_clr);
      underflow_q <= (rd & ~rd_acc) | (underflow_q & ~err_clr);
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`endif

  assign rd_valid     = rd_valid_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = afull_q;
  assign almost_empty = aempty_q;
  assign count        = count_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
module tb_sync_fifo_param;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr = 1'b0;
  logic       rd = 1'b0;
  logic [7:0] bus_in = 8'h00;
  logic [7:0] bus_out;
  logic       rd_valid, full, empty, almost_full, almost_empty;
  logic [2:0] count;
`ifdef FIFO_ERR_EN
  logic       err_clr = 1'b0;
  logic       overflow, underflow;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sync_fifo_param #(
    .DATA_W    (8),
    .DEPTH     (4),
    .AFULL_TH  (3),
    .AEMPTY_TH (1)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr           (wr),
    .bus_in       (bus_in),
    .rd           (rd),
    .bus_out      (bus_out),
    .rd_valid     (rd_valid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
`ifdef FIFO_ERR_EN
    .err_clr      (err_clr),
    .overflow     (overflow),
    .underflow    (underflow),
`endif
    .count        (count)
  );

  typedef struct {
    logic       wr;
    logic [7:0] din;
    logic       rd;
    logic [2:0] cnt;
    logic       full;
    logic       empty;
    logic       af;
    logic       ae;
    logic       rv;
    logic [7:0] bus;
  } vec_t;

  vec_t vecs [22];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [2:0] c, input logic f, input logic e,
                         input logic af, input logic ae, input logic rv, input logic [7:0] b);
    chk({tag, " count"}, 32'(count), 32'(c));
    chk({tag, " full"}, 32'(full), 32'(f));
    chk({tag, " empty"}, 32'(empty), 32'(e));
    chk({tag, " almost_full"}, 32'(almost_full), 32'(af));
    chk({tag, " almost_empty"}, 32'(almost_empty), 32'(ae));
    chk({tag, " rd_valid"}, 32'(rd_valid), 32'(rv));
    chk({tag, " bus_out"}, 32'(bus_out), 32'(b));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //          wr  din    rd   cnt   f     e     af    ae    rv    bus
    vecs[0]  = '{1'b1, 8'h11, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00};
    vecs[1]  = '{1'b1, 8'h22, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[2]  = '{1'b1, 8'h33, 1'b0, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
    vecs[3]  = '{1'b1, 8'h44, 1'b0, 3'd4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
    vecs[4]  = '{1'b1, 8'h55, 1'b0, 3'd4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
    vecs[5]  = '{1'b0, 8'h00, 1'b1, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h11};
    vecs[6]  = '{1'b0, 8'h00, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h22};
    vecs[7]  = '{1'b0, 8'h00, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h33};
    vecs[8]  = '{1'b0, 8'h00, 1'b1, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h44};
    vecs[9]  = '{1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h44};
    vecs[10] = '{1'b0, 8'h00, 1'b1, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h44};
    vecs[11] = '{1'b1, 8'h01, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h44};
    vecs[12] = '{1'b1, 8'h02, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h44};
    vecs[13] = '{1'b1, 8'h03, 1'b0, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h44};
    vecs[14] = '{1'b1, 8'h04, 1'b0, 3'd4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h44};
    vecs[15] = '{1'b1, 8'h66, 1'b1, 3'd4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h01};
    vecs[16] = '{1'b0, 8'h00, 1'b1, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h02};
    vecs[17] = '{1'b0, 8'h00, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h03};
    vecs[18] = '{1'b0, 8'h00, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h04};
    vecs[19] = '{1'b0, 8'h00, 1'b1, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h66};
    vecs[20] = '{1'b1, 8'hA5, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h66};
    vecs[21] = '{1'b0, 8'h00, 1'b1, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA5};

    // Reset state
    #12;
    chk_all("reset", 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    for (int i = 0; i < 22; i++) begin
      wr     = vecs[i].wr;
      bus_in = vecs[i].din;
      rd     = vecs[i].rd;
      step();
      chk_all($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].full, vecs[i].empty,
              vecs[i].af, vecs[i].ae, vecs[i].rv, vecs[i].bus);
`ifdef FIFO_ERR_EN
      if (i == 4) chk("overflow after dropped write", 32'(overflow), 32'd1);
`endif
    end

    // Streaming write/read pairs; pointers wrap several times.
    wr = 1'b1; rd = 1'b0; bus_in = 8'h80;
    step();
    chk_all("stream fill", 3'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA5);
    for (int i = 1; i < 10; i++) begin
      wr = 1'b1; rd = 1'b1; bus_in = 8'(8'h80 + i);
      step();
      chk_all($sformatf("stream%0d", i), 3'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'(8'h80 + i - 1));
    end
    wr = 1'b0; rd = 1'b1;
    step();
    chk_all("stream drain", 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h89);

    // Asynchronous reset mid-stream with count 2 and rd_valid high.
    wr = 1'b1; rd = 1'b0;
    bus_in = 8'hC1; step();
    bus_in = 8'hC2; step();
    bus_in = 8'hC3; step();
    wr = 1'b0; rd = 1'b1;
    step();
    chk_all("pre-reset", 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hC1);
    rd = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("async reset", 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    rd = 1'b1;
    step();
    chk_all("post-reset rd", 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
    rd = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
